param_sdp_ram: RTL and testbench
================================

Name: param_sdp_ram

Overview:
- Parametrised simple-dual-port RAM (one write port, one read port) with byte enables and registered reads.
- Selectable read-during-write mode and a hardware clear engine that zero-fills the array after reset or on request.
- Successor to the fixed 8x8 single-port RAM; used as the generic scratch/buffer memory behind FIFOs and register banks.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8 (elaboration error otherwise).
- DEPTH, 16: number of words; any value >= 2, power of two not required.
- ADDR_W, $clog2(DEPTH): address width (derived, not overridden).
- RDW_MODE, 0: same-address read-during-write; 0 = WRITE_FIRST (new data), 1 = READ_FIRST (old data).
- OUT_REG, 0: 1 adds an output pipeline register (read latency 2 instead of 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  pulse; starts a zero-fill of the whole array.
- busy  out  1  high while reset is asserted or a clear is running; ports are ignored while high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data, held between reads.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.

Behaviour:
- Reset values: busy=1, rd_valid=0, rd_data=0, FSM=CLEAR, clr_cnt=0. The array is not reset directly; the clear engine fills it.
- FSM states and transitions:
  - CLEAR: writes 0 to mem[clr_cnt] each cycle and increments clr_cnt. At clr_cnt==DEPTH-1, writes the last word and goes to IDLE.
  - IDLE: if clr_req, goes to CLEAR with clr_cnt=0 on the next edge.
- Clear timing: busy=1 for exactly DEPTH cycles after rst deasserts. busy is registered and drops the cycle after the final clear write.
- Clear requests: clr_req in IDLE gives busy=1 from the next cycle for DEPTH cycles. clr_req during CLEAR is ignored and does not restart the count.
- Reset mid-clear: returns to CLEAR with clr_cnt=0, so the full fill reruns.
- Port gating: while busy=1, wr_en and rd_en are ignored. No write, no rd_valid, and rd_data holds.
- clr_req in the same cycle as wr_en/rd_en in IDLE: the accesses complete normally and the clear starts next cycle.
- Write: on a rising edge with wr_en && !busy, updates only the enabled bytes of mem[wr_addr]. wr_be=0 is a no-op.
- Read latency: rd_en && !busy in cycle N gives rd_valid=1 and rd_data in cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
- Read throughput: back-to-back reads give one result per cycle. rd_data updates only with rd_valid.
- Same-address read-during-write (rd_en && wr_en, rd_addr==wr_addr, same cycle):
  - WRITE_FIRST: returns the byte-merged new word (old bytes where wr_be=0).
  - READ_FIRST: returns the pre-write word.
- Different-address simultaneous read and write are independent.
- Out-of-range address (>= DEPTH, non-power-of-two DEPTH only):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- Reset also flushes the OUT_REG pipeline stage: no stale rd_valid after reset.

Decomposition:
- Package ram_pkg:
  - constants RDW_WRITE_FIRST=0, RDW_READ_FIRST=1.
  - enum clr_state_t {CLEAR, IDLE}.
  - function be_merge(old, new, be) returning the byte-merged word.
- Sub-module ram_clear_fsm: owns the FSM, clr_cnt and busy. Outputs clr_we and clr_addr, which the top muxes onto the write port (clear has priority; user writes are gated by busy).
- Array, read path and OUT_REG stage stay in param_sdp_ram.

Test Plan:
1. Reset release, DEPTH=16 -> busy high exactly 16 cycles. Reads of all 16 addresses then return 0x00000000, each with rd_valid one cycle after rd_en.
2. Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then wr_data 0x11223344 with wr_be=4'b0101 -> read of addr 3 returns 0xDE22BE44.
3. Same-cycle wr_en/rd_en at addr 5 (old 0xAAAAAAAA, new 0x55555555, be=4'b1111) -> rd_data 0x55555555 with RDW_MODE=0, 0xAAAAAAAA with RDW_MODE=1.
4. OUT_REG=1, rd_en pulsed on addresses 0,1,2 in consecutive cycles -> three rd_valid pulses in cycles N+2..N+4 with matching data.
5. After data is written, clr_req pulse -> busy 16 cycles. clr_req again at clear cycle 8 does not extend busy. All words read 0 afterwards, and wr_en during busy leaves no trace.
6. DEPTH=12, assert rst at clear cycle 5 -> busy stays high and a full 12-cycle clear reruns after release. Write to addr 13 is dropped, and a read of addr 13 gives 0 with rd_valid=1.

Source files
------------

// File: rtl/param_sdp_ram_pkg.sv
// Shared types and helpers for the parametrised simple-dual-port RAM and its clear engine.
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Widest word be_merge can handle; callers extend their operands to this width.
    localparam int BE_MAX_W = 1024;

    typedef enum logic {
        CLEAR,
        IDLE
    } clr_state_t;

    function automatic logic [BE_MAX_W-1:0] be_merge(
        input logic [BE_MAX_W-1:0]   old_word,
        input logic [BE_MAX_W-1:0]   new_word,
        input logic [BE_MAX_W/8-1:0] be
    );
        logic [BE_MAX_W-1:0] result;
        result = old_word;
        for (int i = 0; i < BE_MAX_W / 8; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/param_sdp_ram_if.sv
// Write/read/clear bus of the simple-dual-port RAM; master drives requests, slave is the RAM.
interface ram_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  clr_req;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );

endinterface

// File: rtl/param_sdp_ram_clear_fsm.sv
// Zero-fill engine: walks every address once after reset or on request, holding busy meanwhile.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_we,
    output logic [$clog2(DEPTH)-1:0] clr_addr
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] clr_cnt, cnt_next;
    logic              busy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            state   <= state_next;
            clr_cnt <= cnt_next;
            busy    <= busy_next;
        end
    end

    // Requests arriving mid-clear are dropped so the fill always runs to completion once.
    always_comb begin
        state_next = state;
        cnt_next   = clr_cnt;
        busy_next  = 1'b0;
        case (state)
            CLEAR: begin
                busy_next = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = clr_cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/param_sdp_ram.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write behaviour,
// optional output register and a zero-fill clear engine.
module param_sdp_ram
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int RDW_MODE = RDW_WRITE_FIRST,
    parameter int OUT_REG  = 0
) (
    input  logic clk,
    input  logic rst,
    ram_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (DATA_W % 8 != 0 || DATA_W > BE_MAX_W) begin : g_bad_width
        $error("param_sdp_ram: DATA_W must be a multiple of 8 and at most %0d", BE_MAX_W);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("param_sdp_ram: DEPTH must be at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_in_range, rd_in_range;
    logic              user_we, rd_fire;
    logic [DATA_W-1:0] old_word, merged_word, rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    ram_clear_fsm #(.DEPTH(DEPTH)) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy    = busy;
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
    assign user_we     = bus.wr_en && !busy && wr_in_range && (|bus.wr_be);
    assign rd_fire     = bus.rd_en && !busy;
    assign old_word    = mem[bus.wr_addr];
    assign merged_word = DATA_W'(be_merge(BE_MAX_W'(old_word), BE_MAX_W'(bus.wr_data),
                                          (BE_MAX_W/8)'(bus.wr_be)));

    // The clear engine owns the write port while busy, which already locks out user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
        end else if (user_we) begin
            mem_we    = 1'b1;
            mem_waddr = bus.wr_addr;
            mem_wdata = merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first forwards the merged word on an address collision; read-first sees the array.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
            if (RDW_MODE == RDW_WRITE_FIRST && user_we && bus.wr_addr == bus.rd_addr) begin
                rd_word = merged_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_valid <= 1'b0;
                pipe_data  <= '0;
            end else begin
                pipe_valid <= rd_fire;
                if (rd_fire) begin
                    pipe_data <= rd_word;
                end
            end
        end
    end else begin : g_no_out_reg
        assign pipe_valid = rd_fire;
        assign pipe_data  = rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pipe_valid;
            if (pipe_valid) begin
                rd_data_q <= pipe_data;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_param_sdp_ram.sv
// Drives four RAM configurations with one shared stimulus stream and checks each
// against a per-configuration behavioural model every cycle.
module tb_param_sdp_ram;
    import ram_pkg::*;

    localparam int NCFG = 4;
    localparam int CFG_DEPTH [NCFG] = '{16, 16, 12, 12};
    localparam int CFG_RDW   [NCFG] = '{RDW_WRITE_FIRST, RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_READ_FIRST};
    localparam int CFG_OREG  [NCFG] = '{0, 1, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr_req, wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_data;

    logic        busy_o     [NCFG];
    logic        rd_valid_o [NCFG];
    logic [31:0] rd_data_o  [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        ram_if #(.DATA_W(32), .DEPTH(CFG_DEPTH[g])) bus ();

        assign bus.clr_req = clr_req;
        assign bus.wr_en   = wr_en;
        assign bus.wr_addr = wr_addr;
        assign bus.wr_data = wr_data;
        assign bus.wr_be   = wr_be;
        assign bus.rd_en   = rd_en;
        assign bus.rd_addr = rd_addr;
        assign busy_o[g]     = bus.busy;
        assign rd_valid_o[g] = bus.rd_valid;
        assign rd_data_o[g]  = bus.rd_data;

        param_sdp_ram #(
            .DATA_W   (32),
            .DEPTH    (CFG_DEPTH[g]),
            .RDW_MODE (CFG_RDW[g]),
            .OUT_REG  (CFG_OREG[g])
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Reference state: word contents, cycles of clearing left, and the read result timeline.
    logic [31:0] m_mem [NCFG][16];
    int          m_busy_left [NCFG];
    bit          m_stage_v [NCFG];
    logic [31:0] m_stage_d [NCFG];
    bit          m_out_v [NCFG];
    logic [31:0] m_out_d [NCFG];

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mergeRef(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < NCFG; k++) begin
            bit          fire;
            logic [31:0] val;
            if (rst) begin
                m_busy_left[k] = CFG_DEPTH[k];
                m_stage_v[k]   = 1'b0;
                m_out_v[k]     = 1'b0;
                m_out_d[k]     = '0;
                for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
                continue;
            end
            fire = rd_en && (m_busy_left[k] == 0);
            val  = '0;
            if (fire && int'(rd_addr) < CFG_DEPTH[k]) begin
                val = m_mem[k][rd_addr];
                if (CFG_RDW[k] == RDW_WRITE_FIRST && wr_en && wr_addr == rd_addr)
                    val = mergeRef(val, wr_data, wr_be);
            end
            if (CFG_OREG[k] != 0) begin
                m_out_v[k] = m_stage_v[k];
                if (m_stage_v[k]) m_out_d[k] = m_stage_d[k];
                m_stage_v[k] = fire;
                m_stage_d[k] = val;
            end else begin
                m_out_v[k] = fire;
                if (fire) m_out_d[k] = val;
            end
            if (m_busy_left[k] == 0 && wr_en && int'(wr_addr) < CFG_DEPTH[k])
                m_mem[k][wr_addr] = mergeRef(m_mem[k][wr_addr], wr_data, wr_be);
            if (m_busy_left[k] > 0) begin
                m_busy_left[k]--;
            end else if (clr_req) begin
                m_busy_left[k] = CFG_DEPTH[k];
                for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
            end
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < NCFG; k++) begin
            checkOutput($sformatf("busy[%0d]", k), 32'(busy_o[k]),
                        32'((rst === 1'b1) || (m_busy_left[k] > 0)));
            checkOutput($sformatf("rd_valid[%0d]", k), 32'(rd_valid_o[k]), 32'(m_out_v[k]));
            checkOutput($sformatf("rd_data[%0d]", k), rd_data_o[k], m_out_d[k]);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic we, input logic [3:0] wa,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic re, input logic [3:0] ra);
        rst = r; clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic doWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        applyStimulus(1'b0, 1'b0, 1'b1, a, d, be, 1'b0, 4'd0);
    endtask

    task automatic doRead(input logic [3:0] a);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a);
    endtask

    // Counts the edges at which each DEPTH=16 / DEPTH=12 instance presents busy.
    task automatic runCountingBusy(input int n, input int req_at, input int acc_at,
                                   output int c16, output int c12);
        c16 = 0;
        c12 = 0;
        for (int i = 0; i < n; i++) begin
            if (busy_o[0]) c16++;
            if (busy_o[2]) c12++;
            applyStimulus(1'b0, i == req_at, i == acc_at, 4'd7, 32'h0BAD0BAD, 4'hF, i == acc_at, 4'd7);
        end
    endtask

    initial begin
        int          c16, c12;
        logic [31:0] vals [3];
        logic        r, c, we, re;
        logic [3:0]  wa, ra, be;
        logic [31:0] wd;

        $display("[TB] start");
        resetCycles(3);

        runCountingBusy(20, -1, -1, c16, c12);
        checkOutput("reset_busy_cycles_d16", 32'(c16), 32'd16);
        checkOutput("reset_busy_cycles_d12", 32'(c12), 32'd12);
        for (int a = 0; a < 16; a++) begin
            doRead(4'(a));
            checkOutput("post_reset_valid", 32'(rd_valid_o[0]), 32'd1);
            checkOutput("post_reset_zero", rd_data_o[0], 32'd0);
        end
        idle(2);

        doWrite(4'd3, 32'hDEADBEEF, 4'b1111);
        doWrite(4'd3, 32'h11223344, 4'b0101);
        doRead(4'd3);
        checkOutput("be_merge_lat1", rd_data_o[0], 32'hDE22BE44);
        idle(1);
        checkOutput("be_merge_lat2", rd_data_o[1], 32'hDE22BE44);

        doWrite(4'd5, 32'hAAAAAAAA, 4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 32'h55555555, 4'b1111, 1'b1, 4'd5);
        checkOutput("rdw_write_first", rd_data_o[0], 32'h55555555);
        checkOutput("rdw_read_first", rd_data_o[3], 32'hAAAAAAAA);
        idle(1);
        checkOutput("rdw_read_first_oreg", rd_data_o[1], 32'hAAAAAAAA);
        checkOutput("rdw_write_first_oreg", rd_data_o[2], 32'h55555555);
        idle(2);

        vals = '{32'h10203040, 32'h50607080, 32'h90A0B0C0};
        for (int i = 0; i < 3; i++) doWrite(4'(i), vals[i], 4'hF);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) doRead(4'(i));
            else idle(1);
            checkOutput("oreg_valid_timing", 32'(rd_valid_o[1]), 32'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) checkOutput("oreg_data", rd_data_o[1], vals[i-1]);
        end

        doWrite(4'd9, 32'h12345678, 4'hF);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        runCountingBusy(24, 7, 3, c16, c12);
        checkOutput("clear_busy_cycles_d16", 32'(c16), 32'd16);
        checkOutput("clear_busy_cycles_d12", 32'(c12), 32'd12);
        for (int a = 0; a < 16; a++) begin
            doRead(4'(a));
            checkOutput("post_clear_zero", rd_data_o[0], 32'd0);
        end
        idle(2);

        resetCycles(2);
        idle(5);
        resetCycles(2);
        runCountingBusy(20, -1, -1, c16, c12);
        checkOutput("rerun_busy_cycles_d16", 32'(c16), 32'd16);
        checkOutput("rerun_busy_cycles_d12", 32'(c12), 32'd12);
        doWrite(4'd13, 32'hCAFEF00D, 4'hF);
        doRead(4'd13);
        checkOutput("oor_read_valid", 32'(rd_valid_o[3]), 32'd1);
        checkOutput("oor_read_zero", rd_data_o[3], 32'd0);
        checkOutput("in_range_13", rd_data_o[0], 32'hCAFEF00D);
        doRead(4'd1);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 249) == 0);
            c  = ($urandom_range(0, 59) == 0);
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            applyStimulus(r, c, we, wa, wd, be, re, ra);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
